// File: rtl/vga_rect_fill_if.sv
// rtl/vga_rect_fill_if.sv - request and pixel-write bundle between a fill client and vga_rect_fill
interface vga_rect_fill_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
);
   logic                start;
   logic [X_W-1:0]      x0;
   logic [Y_W-1:0]      y0;
   logic [X_W-1:0]      w;
   logic [Y_W-1:0]      h;
   logic [COLOUR_W-1:0] colour;

   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour_out;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (
      output start, x0, y0, w, h, colour,
      input  x, y, colour_out, plot, busy, done
   );

   modport slave (
      input  start, x0, y0, w, h, colour,
      output x, y, colour_out, plot, busy, done
   );
endinterface

// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - raster-order rectangle fill engine feeding vga_adapter, one pixel per clock
module vga_rect_fill #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int MAX_X    = 159,
   parameter int MAX_Y    = 119
) (
   input  logic             clock,
   input  logic             resetn,
   vga_rect_fill_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [X_W:0] MAX_XW = MAX_X[X_W:0];
   localparam logic [Y_W:0] MAX_YW = MAX_Y[Y_W:0];

   state_t              state, state_n;
   logic [X_W-1:0]      x_r, x_n;
   logic [Y_W-1:0]      y_r, y_n;
   logic [X_W-1:0]      x0_l, x0_n;
   logic [X_W-1:0]      xe_l, xe_n;
   logic [Y_W-1:0]      ye_l, ye_n;
   logic [COLOUR_W-1:0] col_r, col_n;
   logic                plot_r, plot_n;
   logic                busy_r, busy_n;
   logic                done_r, done_n;

   // One extra bit on the far corner so x0+w-1 never wraps before clipping.
   logic [X_W:0]        x_last;
   logic [Y_W:0]        y_last;
   logic [X_W-1:0]      x_clip;
   logic [Y_W-1:0]      y_clip;
   logic                req_empty;

   assign x_last = {1'b0, bus.x0} + {1'b0, bus.w} - {{X_W{1'b0}}, 1'b1};
   assign y_last = {1'b0, bus.y0} + {1'b0, bus.h} - {{Y_W{1'b0}}, 1'b1};

   assign x_clip = (x_last > MAX_XW) ? MAX_XW[X_W-1:0] : x_last[X_W-1:0];
   assign y_clip = (y_last > MAX_YW) ? MAX_YW[Y_W-1:0] : y_last[Y_W-1:0];

   assign req_empty = (bus.w == '0) || (bus.h == '0) ||
                      ({1'b0, bus.x0} > MAX_XW) || ({1'b0, bus.y0} > MAX_YW);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         x_r    <= '0;
         y_r    <= '0;
         x0_l   <= '0;
         xe_l   <= '0;
         ye_l   <= '0;
         col_r  <= '0;
         plot_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= state_n;
         x_r    <= x_n;
         y_r    <= y_n;
         x0_l   <= x0_n;
         xe_l   <= xe_n;
         ye_l   <= ye_n;
         col_r  <= col_n;
         plot_r <= plot_n;
         busy_r <= busy_n;
         done_r <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      x_n     = x_r;
      y_n     = y_r;
      x0_n    = x0_l;
      xe_n    = xe_l;
      ye_n    = ye_l;
      col_n   = col_r;
      plot_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (req_empty) begin
                  state_n = FIN;
                  done_n  = 1'b1;
               end else begin
                  state_n = DRAW;
                  x_n     = bus.x0;
                  y_n     = bus.y0;
                  x0_n    = bus.x0;
                  xe_n    = x_clip;
                  ye_n    = y_clip;
                  col_n   = bus.colour;
                  plot_n  = 1'b1;
                  busy_n  = 1'b1;
               end
            end
         end

         DRAW: begin
            if (x_r < xe_l) begin
               x_n    = x_r + 1'b1;
               plot_n = 1'b1;
               busy_n = 1'b1;
            end else if (y_r < ye_l) begin
               x_n    = x0_l;
               y_n    = y_r + 1'b1;
               plot_n = 1'b1;
               busy_n = 1'b1;
            end else begin
               // Last pixel already on the bus: x/y hold it while done pulses.
               state_n = FIN;
               done_n  = 1'b1;
            end
         end

         FIN: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.x          = x_r;
   assign bus.y          = y_r;
   assign bus.colour_out = col_r;
   assign bus.plot       = plot_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb/tb_vga_rect_fill.sv - directed table-driven bench for vga_rect_fill
module tb_vga_rect_fill;
   logic clock;
   logic resetn;

   vga_rect_fill_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

   vga_rect_fill dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    x0;
      int    y0;
      int    w;
      int    h;
      int    col;
      int    exp_plots;
   } vec_t;

   int checks;
   int errors;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Starts a fill and follows it to done; poke_at >= 0 fires a competing start mid-fill.
   task automatic run_fill(input string name, input int x0, input int y0, input int w,
                           input int h, input int col, input int exp_plots, input int poke_at);
      int ex[$];
      int ey[$];
      int k;
      int cyc;
      for (int py = y0; py < y0 + h; py++)
         for (int px = x0; px < x0 + w; px++)
            if (px <= 159 && py <= 119) begin
               ex.push_back(px);
               ey.push_back(py);
            end

      @(negedge clock);
      bus.x0     = x0[7:0];
      bus.y0     = y0[6:0];
      bus.w      = w[7:0];
      bus.h      = h[6:0];
      bus.colour = col[2:0];
      bus.start  = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;

      k   = 0;
      cyc = 0;
      while (bus.plot && cyc < 20000) begin
         if (k < ex.size())
            check({name, " pixel"},
                  {20'd0, bus.busy, bus.x, bus.y, bus.colour_out},
                  {20'd0, 1'b1, ex[k][7:0], ey[k][6:0], col[2:0]});
         else
            check({name, " extra pixel"}, k, ex.size() - 1);
         k++;
         if (k - 1 == poke_at) begin
            bus.start  = 1'b1;
            bus.x0     = 8'd100;
            bus.colour = ~col[2:0];
         end else begin
            bus.start = 1'b0;
         end
         cyc++;
         @(negedge clock);
      end
      bus.start = 1'b0;

      check({name, " plot count"}, k, exp_plots);
      check({name, " done after last"}, int'(bus.done), 1);
      check({name, " busy in fin"}, int'(bus.busy), 0);
      if (exp_plots > 0)
         check({name, " last pixel hold"}, {17'd0, bus.x, bus.y},
               {17'd0, ex[ex.size()-1][7:0], ey[ey.size()-1][6:0]});
      @(negedge clock);
      check({name, " done one cycle"}, int'(bus.done), 0);
   endtask

   vec_t vecs[10];

   initial begin
      int seen;
      int first;
      int second;
      int donec;

      vecs[0] = '{"basic2x2",  10,  12,   2,   2, 5,   4};
      vecs[1] = '{"empty_w",   10,  12,   0,   5, 3,   0};
      vecs[2] = '{"clip",     158, 118,   4,   4, 2,   4};
      vecs[3] = '{"offscr_x", 200,  10,   4,   4, 1,   0};
      vecs[4] = '{"offscr_y",  10, 120,   4,   4, 1,   0};
      vecs[5] = '{"empty_h",    5,   5,   3,   0, 7,   0};
      vecs[6] = '{"corner1x1", 159, 119,  1,   1, 6,   1};
      vecs[7] = '{"row3",      40,  50,   3,   1, 4,   3};
      vecs[8] = '{"wide_row",   0,   0, 255,   1, 3, 160};
      vecs[9] = '{"clear",      0,   0, 160, 120, 0, 19200};

      checks = 0;
      errors = 0;
      resetn     = 1'b0;
      bus.start  = 1'b0;
      bus.x0     = '0;
      bus.y0     = '0;
      bus.w      = '0;
      bus.h      = '0;
      bus.colour = '0;

      repeat (2) @(negedge clock);
      check("reset outputs",
            {17'd0, bus.x, bus.y, bus.colour_out, bus.plot, bus.busy, bus.done}, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      check("idle quiet", {29'd0, bus.plot, bus.busy, bus.done}, 0);

      for (int i = 0; i < 10; i++)
         run_fill(vecs[i].name, vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
                  vecs[i].col, vecs[i].exp_plots, -1);

      run_fill("ignored_start", 20, 30, 8, 8, 2, 64, 5);

      // Reset after the 20th plot of a 10x10 fill.
      @(negedge clock);
      bus.x0 = 8'd5; bus.y0 = 7'd5; bus.w = 8'd10; bus.h = 7'd10; bus.colour = 3'd7;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && seen < 20; c++) begin
         if (bus.plot) seen++;
         if (seen < 20) @(negedge clock);
      end
      check("reset run plots before reset", seen, 20);
      #2 resetn = 1'b0;
      #1 check("async reset drop", {29'd0, bus.plot, bus.busy, bus.done}, 0);
      @(negedge clock);
      resetn = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (bus.plot || bus.busy) seen++;
      end
      check("no plots after reset", seen, 0);
      run_fill("after_reset", 10, 12, 2, 2, 5, 4, -1);

      // start held high: second 1x1 fill begins 3 cycles after the first pixel.
      @(negedge clock);
      bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd1; bus.h = 7'd1; bus.colour = 3'd6;
      bus.start = 1'b1;
      first = -1; second = -1; donec = -1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (bus.plot) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         if (bus.done && donec < 0) donec = c;
         if (second >= 0) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      check("held start first plot", first, 0);
      check("held start refill gap", second - first, 3);
      check("held start done", donec - first, 1);
      repeat (3) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
